// File: rtl/board_ctrl.sv
// -----------------------------------------------------------------------------
// board_ctrl : 2048 game-state controller for the VGA display path.
//
// Holds the 4x4 board as 16 four-bit tile codes (code k = tile 2^k, 0 = empty).
// A move request slides and merges one line per cycle, then spawns a new tile
// and checks whether the game is over. The display side reads the tile code
// of a screen area with one cycle of latency.
//
// Optional feature macro: SCORE_EN (score accumulation). When it is undefined
// there is no score logic and score is tied to zero.
//
// Ports:
//   clk         system clock (pixel pipeline clock)
//   clrn        asynchronous active-low reset
//   move_valid  move request strobe, move_dir sampled with it
//   move_dir    0=up 1=down 2=left 3=right
//   move_ready  high in IDLE while the game is not over
//   load_en     debug board load, honoured only in IDLE without a move
//   load_board  cell n in bits [4n+3:4n], n = row*4+col, row 0 at top
//   area        display region 1..16 selects cell area-1, 0 = background
//   tile_code   registered code of the selected cell (0 outside 1..16)
//   busy        high whenever the controller is not in IDLE
//   won         sticky, set when a merge creates a code >= WIN_CODE
//   game_over   sticky, board full with no equal orthogonal neighbours
//   score       sum of merged tile values (SCORE_EN), else zero
// -----------------------------------------------------------------------------
module board_ctrl #(
    parameter logic [15:0] SEED     = 16'hACE1,
    parameter logic [3:0]  WIN_CODE = 4'd11
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        move_valid,
    input  logic [1:0]  move_dir,
    output logic        move_ready,
    input  logic        load_en,
    input  logic [63:0] load_board,
    input  logic [5:0]  area,
    output logic [3:0]  tile_code,
    output logic        busy,
    output logic        won,
    output logic        game_over,
    output logic [15:0] score
);

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_SPAWN = 3'd1,
        ST_CHECK = 3'd2,
        ST_IDLE  = 3'd3,
        ST_LINE  = 3'd4
    } state_t;

    typedef struct packed {
        logic [15:0] cells;  // resulting line, element j in [4j+3:4j]
        logic [16:0] pts;    // sum of merged tile values in this line
        logic        win;    // a merge reached WIN_CODE
    } line_res_t;

    // An all-zero LFSR would lock up, so a zero seed is replaced.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    state_t      state_r, state_nxt_s;
    logic [63:0] board_r;
    logic [15:0] lfsr_r;
    logic [1:0]  dir_r, line_r;
    logic        changed_r, spawn_two_r, won_r, game_over_r;
    logic [3:0]  probe_p_r, probe_cnt_r, tile_code_r;
    logic [15:0] line_in_s;
    line_res_t   line_res_s;
    logic        line_changed_s, probe_empty_s, spawn_done_s, move_take_s, load_take_s;
    logic [3:0]  area_idx_s, spawn_code_s;

    // Cell index of element j (j=0 at the leading edge) of a line for a direction.
    function automatic logic [3:0] cell_idx(input logic [1:0] dir, input logic [1:0] line,
                                            input logic [1:0] j);
        logic [3:0] idx;
        case (dir)
            2'd0:    idx = {j, line};    // up:    j*4 + line
            2'd1:    idx = {~j, line};   // down:  (3-j)*4 + line
            2'd2:    idx = {line, j};    // left:  line*4 + j
            2'd3:    idx = {line, ~j};   // right: line*4 + 3-j
            default: idx = 4'd0;
        endcase
        return idx;
    endfunction

    // Compress a line toward element 0, then merge equal pairs once, ascending.
    function automatic line_res_t slide_line(input logic [15:0] cells_in);
        logic [3:0] comp [0:4];
        logic [2:0] wr;
        logic       skip;
        line_res_t  res;
        for (int k = 0; k < 5; k++) comp[k] = 4'h0;
        wr = 3'd0;
        for (int j = 0; j < 4; j++) begin
            if (cells_in[j*4 +: 4] != 4'h0) begin
                comp[wr] = cells_in[j*4 +: 4];
                wr       = wr + 3'd1;
            end
        end
        res  = '0;
        wr   = 3'd0;
        skip = 1'b0;
        for (int j = 0; j < 4; j++) begin
            if (skip) begin
                skip = 1'b0;     // second half of a pair already merged
            end else if (comp[j] != 4'h0) begin
                // comp[4] is always empty, so the last element never pairs.
                if ((comp[j] == comp[j+1]) && (comp[j] != 4'd15)) begin
                    res.cells[{wr[1:0], 2'b00} +: 4] = comp[j] + 4'd1;
                    res.pts = res.pts + (17'd1 << (comp[j] + 4'd1));
                    if ((comp[j] + 4'd1) >= WIN_CODE) res.win = 1'b1;
                    skip = 1'b1;
                end else begin
                    res.cells[{wr[1:0], 2'b00} +: 4] = comp[j];
                end
                wr = wr + 3'd1;
            end
        end
        return res;
    endfunction

    // Board is dead when no cell is empty and no orthogonal neighbours match.
    function automatic logic board_dead(input logic [63:0] b);
        logic dead;
        dead = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (b[(r*4+c)*4 +: 4] == 4'h0) begin
                    dead = 1'b0;
                end else if ((c < 3) && (b[(r*4+c)*4 +: 4] == b[(r*4+((c+1)&3))*4 +: 4])) begin
                    dead = 1'b0;
                end else if ((r < 3) && (b[(r*4+c)*4 +: 4] == b[(((r+1)&3)*4+c)*4 +: 4])) begin
                    dead = 1'b0;
                end
            end
        end
        return dead;
    endfunction

    // Gather the active line in leading-edge order and evaluate its move.
    always_comb begin
        line_in_s = 16'h0000;
        for (int j = 0; j < 4; j++) begin
            line_in_s[j*4 +: 4] = board_r[{cell_idx(dir_r, line_r, 2'(j)), 2'b00} +: 4];
        end
        line_res_s     = slide_line(line_in_s);
        line_changed_s = (line_res_s.cells != line_in_s);
    end

    assign probe_empty_s = (board_r[{probe_p_r, 2'b00} +: 4] == 4'h0);
    assign spawn_done_s  = probe_empty_s || (probe_cnt_r == 4'd15);
    assign spawn_code_s  = (lfsr_r[7:4] == 4'h0) ? 4'd2 : 4'd1;
    assign move_take_s   = move_valid && !game_over_r;
    assign load_take_s   = load_en && !move_valid;
    assign area_idx_s    = area[3:0] - 4'd1;   // area 16 wraps to cell 15

    // Free-running Fibonacci LFSR, taps 16,14,13,11.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            lfsr_r <= SEED_EFF;
        end else begin
            lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_INIT: state_nxt_s = ST_SPAWN;
            ST_IDLE: begin
                if (move_take_s) state_nxt_s = ST_LINE;
                else             state_nxt_s = ST_IDLE;
            end
            ST_LINE: begin
                if (line_r != 2'd3)                      state_nxt_s = ST_LINE;
                else if (changed_r || line_changed_s)    state_nxt_s = ST_SPAWN;
                else                                     state_nxt_s = ST_IDLE;
            end
            ST_SPAWN: begin
                if (!spawn_done_s)   state_nxt_s = ST_SPAWN;
                else if (spawn_two_r) state_nxt_s = ST_SPAWN;   // second starting tile
                else                 state_nxt_s = ST_CHECK;
            end
            ST_CHECK: state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_INIT;
        endcase
    end

    // Board, move context, spawn probe and sticky status flags.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            board_r     <= 64'h0;
            dir_r       <= 2'd0;
            line_r      <= 2'd0;
            changed_r   <= 1'b0;
            spawn_two_r <= 1'b0;
            probe_p_r   <= 4'd0;
            probe_cnt_r <= 4'd0;
            won_r       <= 1'b0;
            game_over_r <= 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    board_r     <= 64'h0;
                    spawn_two_r <= 1'b1;
                    probe_p_r   <= lfsr_r[3:0];
                    probe_cnt_r <= 4'd0;
                end
                ST_IDLE: begin
                    if (move_take_s) begin
                        dir_r     <= move_dir;
                        line_r    <= 2'd0;
                        changed_r <= 1'b0;
                    end else if (load_take_s) begin
                        board_r     <= load_board;
                        won_r       <= 1'b0;
                        game_over_r <= 1'b0;
                    end
                end
                ST_LINE: begin
                    for (int j = 0; j < 4; j++) begin
                        board_r[{cell_idx(dir_r, line_r, 2'(j)), 2'b00} +: 4] <= line_res_s.cells[j*4 +: 4];
                    end
                    changed_r <= changed_r | line_changed_s;
                    won_r     <= won_r | line_res_s.win;
                    line_r    <= line_r + 2'd1;
                    // Reloaded every line; the value from the last line seeds the spawn probe.
                    probe_p_r   <= lfsr_r[3:0];
                    probe_cnt_r <= 4'd0;
                end
                ST_SPAWN: begin
                    if (probe_empty_s) begin
                        board_r[{probe_p_r, 2'b00} +: 4] <= spawn_code_s;
                    end
                    if (spawn_done_s) begin
                        spawn_two_r <= 1'b0;
                        probe_p_r   <= lfsr_r[3:0];
                        probe_cnt_r <= 4'd0;
                    end else begin
                        probe_p_r   <= probe_p_r + 4'd1;
                        probe_cnt_r <= probe_cnt_r + 4'd1;
                    end
                end
                ST_CHECK: begin
                    if (board_dead(board_r)) game_over_r <= 1'b1;
                end
                default: begin
                    board_r <= board_r;
                end
            endcase
        end
    end

    // Registered tile code lookup for the display.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            tile_code_r <= 4'h0;
        end else if ((area != 6'd0) && (area <= 6'd16)) begin
            tile_code_r <= board_r[{area_idx_s, 2'b00} +: 4];
        end else begin
            tile_code_r <= 4'h0;
        end
    end

`ifdef SCORE_EN
    logic [15:0] score_r;
    logic [17:0] score_sum_s;
    assign score_sum_s = {2'b00, score_r} + {1'b0, line_res_s.pts};

    // Accumulate merge points per line, saturating at 16'hFFFF.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            score_r <= 16'h0000;
        end else if ((state_r == ST_IDLE) && load_take_s) begin
            score_r <= 16'h0000;
        end else if (state_r == ST_LINE) begin
            score_r <= (score_sum_s > 18'h0FFFF) ? 16'hFFFF : score_sum_s[15:0];
        end else begin
            score_r <= score_r;
        end
    end
    assign score = score_r;
`else
    logic unused_pts_s;
    assign unused_pts_s = ^line_res_s.pts;
    assign score        = 16'h0000;
`endif

    assign tile_code  = tile_code_r;
    assign busy       = (state_r != ST_IDLE);
    assign move_ready = (state_r == ST_IDLE) && !game_over_r;
    assign won        = won_r;
    assign game_over  = game_over_r;

endmodule

// File: tb/tb_board_ctrl.sv
// -----------------------------------------------------------------------------
// tb_board_ctrl : self-checking bench for board_ctrl.
// A list-based model (queues per line) predicts every move; the spawned tile
// is checked for position (previously empty cell), count and code, then taken
// into the model. Score is expected only when SCORE_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_board_ctrl;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        move_valid = 1'b0;
    logic [1:0]  move_dir = 2'd0;
    logic        load_en = 1'b0;
    logic [63:0] load_board = 64'h0;
    logic [5:0]  area = 6'd0;
    logic        move_ready, busy, won, game_over;
    logic [3:0]  tile_code;
    logic [15:0] score;

    board_ctrl dut (
        .clk        (clk),
        .clrn       (clrn),
        .move_valid (move_valid),
        .move_dir   (move_dir),
        .move_ready (move_ready),
        .load_en    (load_en),
        .load_board (load_board),
        .area       (area),
        .tile_code  (tile_code),
        .busy       (busy),
        .won        (won),
        .game_over  (game_over),
        .score      (score)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int mb [16];      // model board before the move
    int nb [16];      // model board after the move
    int dut_b [16];   // board as read through area/tile_code
    bit m_won, m_go, mv_changed, mv_win;
    int m_score, mv_pts;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Index of element j of line i, leading edge first.
    function automatic int cell_of(input int dir, input int i, input int j);
        case (dir)
            0:       return j*4 + i;
            1:       return (3-j)*4 + i;
            2:       return i*4 + j;
            default: return i*4 + 3 - j;
        endcase
    endfunction

    // Apply a move to mb, producing nb plus change/points/win information.
    task automatic model_move(input int dir);
        int q[$];
        int r[$];
        int a;
        mv_changed = 0; mv_pts = 0; mv_win = 0;
        for (int i = 0; i < 4; i++) begin
            q.delete(); r.delete();
            for (int j = 0; j < 4; j++)
                if (mb[cell_of(dir, i, j)] != 0) q.push_back(mb[cell_of(dir, i, j)]);
            while (q.size() > 0) begin
                a = q.pop_front();
                if (q.size() > 0 && q[0] == a && a != 15) begin
                    void'(q.pop_front());
                    r.push_back(a + 1);
                    mv_pts += (1 << (a + 1));
                    if (a + 1 >= 11) mv_win = 1;
                end else begin
                    r.push_back(a);
                end
            end
            while (r.size() < 4) r.push_back(0);
            for (int j = 0; j < 4; j++) begin
                nb[cell_of(dir, i, j)] = r[j];
                if (r[j] != mb[cell_of(dir, i, j)]) mv_changed = 1;
            end
        end
    endtask

    function automatic bit model_dead();
        for (int n = 0; n < 16; n++) if (nb[n] == 0) return 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                if (c < 3 && nb[r*4+c] == nb[r*4+c+1]) return 0;
                if (r < 3 && nb[r*4+c] == nb[(r+1)*4+c]) return 0;
            end
        return 1;
    endfunction

    task automatic read_board();
        @(posedge clk); #1;
        for (int n = 0; n < 16; n++) begin
            area = 6'(n + 1);
            @(posedge clk); #1;
            dut_b[n] = int'(tile_code);
        end
        area = 6'd0;
    endtask

    task automatic check_status(input string tag);
        chk_eq({tag, "_won"}, won, m_won);
        chk_eq({tag, "_go"}, game_over, m_go);
`ifdef SCORE_EN
        chk_eq({tag, "_score"}, score, m_score);
`else
        chk_eq({tag, "_score"}, score, 0);
`endif
    endtask

    task automatic do_load(input string tag);
        logic [63:0] v;
        for (int n = 0; n < 16; n++) v[n*4 +: 4] = 4'(mb[n]);
        @(posedge clk); #1;
        load_en = 1'b1; load_board = v;
        @(posedge clk); #1;
        load_en = 1'b0;
        m_won = 0; m_go = 0; m_score = 0;
        check_status(tag);
    endtask

    task automatic do_move(input int dir, input string tag);
        int lat, new_cnt, sp;
        bit ignored;
        ignored = m_go;
        if (ignored) begin
            nb = mb; mv_changed = 0; mv_pts = 0; mv_win = 0;
        end else begin
            model_move(dir);
        end
        @(posedge clk); #1;
        chk_eq({tag, "_ready"}, move_ready, !m_go);
        move_valid = 1'b1; move_dir = 2'(dir);
        @(posedge clk); #1;
        move_valid = 1'b0;
        lat = 0;
        while (busy === 1'b1 && lat < 64) begin
            lat++;
            @(posedge clk); #1;
        end
        if (ignored)          chk_eq({tag, "_lat"}, lat, 0);
        else if (!mv_changed) chk_eq({tag, "_lat"}, lat, 4);
        else                  chk_eq({tag, "_lat_range"}, (lat >= 6 && lat <= 21), 1);
        read_board();
        new_cnt = 0; sp = 0;
        for (int n = 0; n < 16; n++) begin
            if (nb[n] != 0) chk_eq($sformatf("%s_c%0d", tag, n), dut_b[n], nb[n]);
            else if (dut_b[n] != 0) begin new_cnt++; sp = n; end
        end
        if (mv_changed) begin
            chk_eq({tag, "_spawn_cnt"}, new_cnt, 1);
            if (new_cnt == 1) begin
                chk_eq({tag, "_spawn_code"}, (dut_b[sp] == 1 || dut_b[sp] == 2), 1);
                nb[sp] = dut_b[sp];
            end
        end else begin
            chk_eq({tag, "_spawn_cnt"}, new_cnt, 0);
        end
        m_won   = m_won | mv_win;
        m_score = (m_score + mv_pts > 65535) ? 65535 : m_score + mv_pts;
        if (mv_changed && model_dead()) m_go = 1;
        mb = nb;
        check_status(tag);
    endtask

    task automatic set_row0(input int a, input int b, input int c, input int d);
        for (int n = 0; n < 16; n++) mb[n] = 0;
        mb[0] = a; mb[1] = b; mb[2] = c; mb[3] = d;
    endtask

    initial begin
        int nz, okc;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst_tile", tile_code, 0);
        chk_eq("rst_busy", busy, 1);
        chk_eq("rst_ready", move_ready, 0);
        m_won = 0; m_go = 0; m_score = 0;
        check_status("rst");
        clrn = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk_eq("init_busy", busy, 0);
        chk_eq("init_ready", move_ready, 1);
        read_board();
        nz = 0; okc = 1;
        for (int n = 0; n < 16; n++) if (dut_b[n] != 0) begin
            nz++;
            if (dut_b[n] > 2) okc = 0;
        end
        chk_eq("init_tiles", nz, 2);
        chk_eq("init_codes", okc, 1);
        mb = dut_b;

        set_row0(1, 1, 1, 1);   do_load("ld1111");  do_move(2, "m1111");
        set_row0(2, 2, 2, 0);   do_load("ld222");   do_move(2, "m222");
        set_row0(0, 1, 1, 2);   do_load("ld0112");  do_move(3, "m0112");
        set_row0(1, 2, 3, 4);   do_load("ld1234");  do_move(2, "m1234");
        set_row0(15, 15, 0, 0); do_load("ld15");    do_move(2, "m15");

        // Full checkerboard: nothing moves, no check is run.
        for (int n = 0; n < 16; n++) mb[n] = (((n / 4) + (n % 4)) % 2 != 0) ? 2 : 1;
        do_load("ldchk");
        do_move(int'($urandom_range(0, 3)), "mchk");

        // One merge frees cell 3; the spawn fills it and the board is dead.
        for (int n = 4; n < 16; n++) mb[n] = (((n / 4) + (n % 4)) % 2 == 0) ? 3 : 4;
        mb[0] = 5; mb[1] = 5; mb[2] = 7; mb[3] = 6;
        do_load("lddead");
        do_move(2, "mdead");
        do_move(0, "mafter_go");

        // Win and display lookup.
        set_row0(10, 10, 0, 0); do_load("ld10"); do_move(2, "mwin");
        @(posedge clk); #1; area = 6'd1;
        @(posedge clk); #1; chk_eq("area1", tile_code, 11); area = 6'd0;
        @(posedge clk); #1; chk_eq("area0", tile_code, 0);  area = 6'd17;
        @(posedge clk); #1; chk_eq("area17", tile_code, 0); area = 6'd16;
        @(posedge clk); #1; chk_eq("area16", tile_code, mb[15]); area = 6'd0;

        // Randomized boards and moves.
        for (int rnd = 0; rnd < 6; rnd++) begin
            for (int n = 0; n < 16; n++)
                mb[n] = ($urandom_range(0, 9) < 5) ? 0
                      : int'($urandom_range(1, (rnd == 5) ? 15 : 4));
            do_load("ldrnd");
            for (int k = 0; k < 8; k++) do_move(int'($urandom_range(0, 3)), $sformatf("rnd%0d_%0d", rnd, k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
